// File: rtl/spi_mem_pkg.sv
// Shared types for the SPI memory slave: FSM state encoding and R/W command bit values.
package spi_mem_pkg;

    typedef enum logic [2:0] {
        IDLE,
        GET_CMD,
        RD_LOAD,
        RD_SHIFT,
        WR_SHIFT,
        WR_STORE,
        HOLD
    } state_t;

    localparam logic RW_READ  = 1'b1;
    localparam logic RW_WRITE = 1'b0;

endpackage

// File: rtl/spi_mem_slave_burst_pin_sync.sv
// Multi-flop pin synchroniser with an extra history flop for single-clk edge pulses.
module spi_pin_sync #(
    parameter int STAGES  = 2,
    parameter bit RST_VAL = 1'b0
) (
    input  logic clk,
    input  logic reset,
    input  logic pin,
    output logic level,
    output logic rise,
    output logic fall
);
    logic [STAGES-1:0] sync_q;
    logic              prev_q;

    // Reset to the pin's idle level so leaving reset never fakes an edge.
    always_ff @(posedge clk) begin
        if (reset) begin
            sync_q <= {STAGES{RST_VAL}};
            prev_q <= RST_VAL;
        end else begin
            sync_q <= {sync_q[STAGES-2:0], pin};
            prev_q <= sync_q[STAGES-1];
        end
    end

    assign level = sync_q[STAGES-1];
    assign rise  = level & ~prev_q;
    assign fall  = ~level & prev_q;

endmodule

// File: rtl/spi_mem_slave_burst.sv
// SPI mode-0 slave in front of a word memory. Define SPIMEM_BURST_EN for multi-word
// bursts with address auto-increment; otherwise one data word per chip-select.
module spi_mem_slave_burst
    import spi_mem_pkg::*;
#(
    parameter int ADDR_W      = 7,
    parameter int DATA_W      = 8,
    parameter int DEPTH       = 128,
    parameter int SYNC_STAGES = 2
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       sclk_pin,
    input  logic       cs_pin,
    input  logic       mosi_pin,
    output logic       miso_pin,
    output logic       miso_oe,
    output logic       busy,
    output logic       xfer_done,
    output logic [7:0] word_cnt
);
    localparam int SW = (ADDR_W > DATA_W) ? ADDR_W : DATA_W;
    localparam int CW = $clog2(SW + 2);
`ifdef SPIMEM_BURST_EN
    localparam bit BURST = 1'b1;
`else
    localparam bit BURST = 1'b0;
`endif

    logic sclk_rise, sclk_fall, cs_fall, cs_rise, mosi;
    logic sclk_level_unused, cs_level_unused, mosi_rise_unused, mosi_fall_unused;

    spi_pin_sync #(.STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_sclk (
        .clk(clk), .reset(reset), .pin(sclk_pin),
        .level(sclk_level_unused), .rise(sclk_rise), .fall(sclk_fall));
    spi_pin_sync #(.STAGES(SYNC_STAGES), .RST_VAL(1'b1)) u_cs (
        .clk(clk), .reset(reset), .pin(cs_pin),
        .level(cs_level_unused), .rise(cs_rise), .fall(cs_fall));
    spi_pin_sync #(.STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_mosi (
        .clk(clk), .reset(reset), .pin(mosi_pin),
        .level(mosi), .rise(mosi_rise_unused), .fall(mosi_fall_unused));

    state_t              state, state_nxt;
    logic [SW-1:0]       shreg, shreg_nxt;
    logic [ADDR_W-1:0]   addr, addr_nxt;
    logic [CW-1:0]       bit_cnt, bit_nxt;
    logic [7:0]          cnt_nxt;
    logic                miso_nxt, oe_nxt, done_nxt, wr_en;
    logic [DATA_W-1:0]   mem [DEPTH];

    function automatic logic [ADDR_W-1:0] wrap_addr(input logic [ADDR_W-1:0] a);
        return ADDR_W'(32'(a) % DEPTH);
    endfunction

    function automatic logic [ADDR_W-1:0] next_addr(input logic [ADDR_W-1:0] a);
        return (32'(a) == DEPTH - 1) ? '0 : a + 1'b1;
    endfunction

    function automatic logic [7:0] sat_inc(input logic [7:0] c);
        return (c == 8'hFF) ? c : c + 8'd1;
    endfunction

    always_comb begin
        state_nxt = state;
        shreg_nxt = shreg;
        addr_nxt  = addr;
        bit_nxt   = bit_cnt;
        cnt_nxt   = word_cnt;
        miso_nxt  = miso_pin;
        oe_nxt    = miso_oe;
        done_nxt  = 1'b0;
        wr_en     = 1'b0;
        case (state)
            IDLE: if (cs_fall) begin
                state_nxt = GET_CMD;
                bit_nxt   = '0;
                cnt_nxt   = '0;
            end
            GET_CMD: if (sclk_rise) begin
                shreg_nxt = {shreg[SW-2:0], mosi};
                bit_nxt   = bit_cnt + 1'b1;
                // Last bit is R/W; the address is already sitting in the low bits.
                if (bit_cnt == CW'(ADDR_W)) begin
                    addr_nxt  = wrap_addr(shreg[ADDR_W-1:0]);
                    bit_nxt   = '0;
                    state_nxt = (mosi == RW_READ) ? RD_LOAD : WR_SHIFT;
                end
            end
            RD_LOAD: begin
                shreg_nxt = SW'(mem[addr]);
                oe_nxt    = 1'b1;
                bit_nxt   = '0;
                state_nxt = RD_SHIFT;
            end
            RD_SHIFT: if (sclk_fall) begin
                miso_nxt  = shreg[DATA_W-1];
                shreg_nxt = shreg << 1;
                bit_nxt   = bit_cnt + 1'b1;
                if (bit_cnt == CW'(DATA_W - 1)) begin
                    done_nxt = 1'b1;
                    cnt_nxt  = sat_inc(word_cnt);
                    addr_nxt = next_addr(addr);
                    if (BURST) begin
                        state_nxt = RD_LOAD;
                    end else begin
                        state_nxt = HOLD;
                        oe_nxt    = 1'b0;
                    end
                end
            end
            WR_SHIFT: if (sclk_rise) begin
                shreg_nxt = {shreg[SW-2:0], mosi};
                bit_nxt   = bit_cnt + 1'b1;
                if (bit_cnt == CW'(DATA_W - 1)) state_nxt = WR_STORE;
            end
            WR_STORE: begin
                wr_en     = 1'b1;
                done_nxt  = 1'b1;
                cnt_nxt   = sat_inc(word_cnt);
                addr_nxt  = next_addr(addr);
                bit_nxt   = '0;
                state_nxt = BURST ? WR_SHIFT : HOLD;
            end
            default: ;
        endcase
        // Deselect wins everywhere; a WR_STORE in flight still writes via wr_en.
        if (cs_rise) begin
            state_nxt = IDLE;
            oe_nxt    = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            shreg     <= '0;
            addr      <= '0;
            bit_cnt   <= '0;
            word_cnt  <= '0;
            miso_pin  <= 1'b0;
            miso_oe   <= 1'b0;
            xfer_done <= 1'b0;
        end else begin
            state     <= state_nxt;
            shreg     <= shreg_nxt;
            addr      <= addr_nxt;
            bit_cnt   <= bit_nxt;
            word_cnt  <= cnt_nxt;
            miso_pin  <= miso_nxt;
            miso_oe   <= oe_nxt;
            xfer_done <= done_nxt;
        end
    end

    always_ff @(posedge clk) begin
        if (wr_en) mem[addr] <= shreg[DATA_W-1:0];
    end

    assign busy = (state != IDLE);

endmodule

// File: tb/tb_spi_mem_slave_burst.sv
// Randomised bench for spi_mem_slave_burst: pin-level SPI master, transaction-level
// memory model, per-cycle idle checks and a few literal anchors.
module tb_spi_mem_slave_burst;
    localparam int ADDR_W = 7, DATA_W = 8, DEPTH = 128, SYNC_STAGES = 2;
    localparam int H = SYNC_STAGES + 4;
`ifdef SPIMEM_BURST_EN
    localparam bit BURST = 1'b1;
`else
    localparam bit BURST = 1'b0;
`endif

    logic clk = 0, reset = 1, sclk_pin = 0, cs_pin = 1, mosi_pin = 0;
    logic miso_pin, miso_oe, busy, xfer_done;
    logic [7:0] word_cnt;

    spi_mem_slave_burst #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .DEPTH(DEPTH),
                          .SYNC_STAGES(SYNC_STAGES)) dut (
        .clk(clk), .reset(reset), .sclk_pin(sclk_pin), .cs_pin(cs_pin),
        .mosi_pin(mosi_pin), .miso_pin(miso_pin), .miso_oe(miso_oe), .busy(busy),
        .xfer_done(xfer_done), .word_cnt(word_cnt));

    always #5 clk = ~clk;

    int checks = 0, failures = 0, dut_done = 0;
    bit chk_idle = 0;
    logic [7:0] mm [DEPTH];
    bit mk [DEPTH];
    logic [7:0] wq[$], rq[$];
    logic sdummy;

    task automatic check(input string nm, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", nm, got, exp);
        end
    endtask

    always @(negedge clk) begin
        if (xfer_done) dut_done++;
        check("wc_max", 32'(word_cnt <= (BURST ? 8'd255 : 8'd1)), 1);
        if (chk_idle) begin
            check("idle_busy", busy, 0);
            check("idle_oe", miso_oe, 0);
            check("idle_done", xfer_done, 0);
        end
    end

    task automatic clks(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic bitx(input logic v, output logic s);
        mosi_pin = v;
        clks(H);
        s = miso_pin;
        sclk_pin = 1;
        clks(H);
        sclk_pin = 0;
    endtask

    task automatic txn(input logic [7:0] cmd, input int nbits);
        logic s;
        logic [7:0] w, r;
        int k;
        r = 0;
        chk_idle = 0;
        rq.delete();
        cs_pin = 0;
        clks(H);
        for (int i = 7; i >= 0; i--) bitx(cmd[i], s);
        for (int b = 0; b < nbits; b++) begin
            k = b / DATA_W;
            w = (k < wq.size()) ? wq[k] : 8'h00;
            bitx(w[DATA_W-1-(b%DATA_W)], s);
            r = {r[6:0], s};
            if (b % DATA_W == DATA_W - 1) rq.push_back(r);
        end
        clks(H);
        cs_pin = 1;
        clks(SYNC_STAGES + 2);
        check("cs_busy", busy, 0);
        check("cs_oe", miso_oe, 0);
        clks(1);
        chk_idle = 1;
    endtask

    // Model: full words only count; non-burst stops after one; addresses wrap mod DEPTH.
    task automatic run(input logic [7:0] cmd, input int nbits);
        int a, nfull, d0, ak;
        a = int'(cmd[7:1]) % DEPTH;
        nfull = nbits / DATA_W;
        if (!BURST && nfull > 1) nfull = 1;
        d0 = dut_done;
        txn(cmd, nbits);
        check("xfer_cnt", dut_done - d0, nfull);
        check("word_cnt", word_cnt, (nfull > 255) ? 255 : nfull);
        for (int k = 0; k < nfull; k++) begin
            ak = (a + k) % DEPTH;
            if (cmd[0]) begin
                if (mk[ak]) check("rd_word", rq[k], mm[ak]);
            end else begin
                mm[ak] = wq[k];
                mk[ak] = 1;
            end
        end
    endtask

    initial begin
        logic [7:0] c03;
        int nw, part;
        clks(3);
        check("rst_miso", miso_pin, 0);
        check("rst_oe", miso_oe, 0);
        check("rst_busy", busy, 0);
        check("rst_done", xfer_done, 0);
        check("rst_wc", word_cnt, 0);
        reset = 0;
        clks(2);
        chk_idle = 1;

        wq = '{8'h55}; run(8'h02, 8);
        run(8'h03, 8); check("t1_rd", rq[0], 8'h55);

        wq = '{8'h3C}; run(8'h10, 8);
        wq = '{8'b10110000}; run(8'h10, 5);
        run(8'h11, 8); check("t3_rd", rq[0], 8'h3C);

        c03 = 8'h03;
        chk_idle = 0;
        cs_pin = 0;
        clks(H);
        for (int i = 7; i >= 0; i--) bitx(c03[i], sdummy);
        for (int i = 0; i < 3; i++) bitx(1'b0, sdummy);
        reset = 1;
        clks(1);
        check("t4_miso", miso_pin, 0);
        check("t4_oe", miso_oe, 0);
        check("t4_busy", busy, 0);
        check("t4_done", xfer_done, 0);
        check("t4_wc", word_cnt, 0);
        cs_pin = 1;
        clks(2);
        reset = 0;
        clks(SYNC_STAGES + 2);
        chk_idle = 1;
        run(8'h03, 8); check("t4_rd", rq[0], 8'h55);

        for (int i = 0; i < 16; i++) begin
            mosi_pin = 1'($urandom);
            sclk_pin = 1; clks(H);
            sclk_pin = 0; clks(H);
        end
        run(8'h03, 8); check("t6_rd", rq[0], 8'h55);

`ifdef SPIMEM_BURST_EN
        wq = '{8'hA1, 8'hB2}; run(8'hFE, 16);
        check("t2_wc", word_cnt, 2);
        run(8'hFF, 16);
        check("t2_rd0", rq[0], 8'hA1);
        check("t2_rd1", rq[1], 8'hB2);
`else
        wq = '{8'h77}; run(8'h06, 8);
        wq = '{8'h11, 8'h22}; run(8'h04, 16);
        check("t5_wc", word_cnt, 1);
        run(8'h05, 8); check("t5_rd2", rq[0], 8'h11);
        run(8'h07, 8); check("t5_rd3", rq[0], 8'h77);
`endif

        for (int t = 0; t < 24; t++) begin
            logic [6:0] ad;
            ad = ($urandom_range(0, 1) != 0) ? 7'($urandom_range(0, 7)) : 7'($urandom_range(124, 127));
            nw = $urandom_range(0, BURST ? 3 : 2);
            part = ($urandom_range(0, 3) == 0) ? $urandom_range(1, DATA_W - 1) : 0;
            wq.delete();
            for (int k = 0; k <= nw; k++) wq.push_back(8'($urandom));
            run({ad, 1'($urandom)}, nw * DATA_W + part);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/spi_mem_slave_burst.md
Name: spi_mem_slave_burst

Overview:
Parametrised SPI-mode-0 slave fronting an on-chip word memory; the next generation of the team's SPI memory.
- Adds configurable address/data widths, on-chip pin synchronisers, burst transfers with address auto-increment, and abort handling.
- Sits directly behind the board SPI pins; the top level owns the MISO tri-state buffer, driven by miso_oe.

Parameters:
ADDR_W, 7, address bits; command frame is ADDR_W+1 bits.
DATA_W, 8, bits per data word.
DEPTH, 128, memory words; must be ≤ 2**ADDR_W.
SYNC_STAGES, 2, flip-flops per pin synchroniser (≥2).

Ports:
clk  input  1  system clock
reset  input  1  synchronous, active-high reset
sclk_pin  input  1  raw SPI clock, idle low
cs_pin  input  1  raw chip select, active low
mosi_pin  input  1  raw serial data in, MSB first
miso_pin  output  1  serial data out, MSB first
miso_oe  output  1  MISO output enable for the top-level tri-state
busy  output  1  high while a transaction is active
xfer_done  output  1  one-clk pulse per completed data word
word_cnt  output  8  saturating count of words completed in the current transaction

Behaviour:
Interface: one clock; reset is synchronous and active-high (ports clk, reset).
- Reset values: miso_pin=0, miso_oe=0, busy=0, xfer_done=0, word_cnt=0, FSM=IDLE, shift register and address counter=0. Memory contents are not cleared.
- Pins pass through SYNC_STAGES flops plus one edge-detect flop, giving sclk_rise/sclk_fall/cs_fall/cs_rise single-clk pulses.
- Requirement on the master: sclk high and low phases each ≥ SYNC_STAGES+3 clk periods.
- Sampling: MOSI sampled on sclk_rise. MISO updated on sclk_fall, registered, mode 0.
- Command frame: ADDR_W address bits MSB first, then R/W bit (1=read, 0=write).
- FSM states:
  - IDLE: on cs_fall -> GET_CMD; clear bit counter and word_cnt; busy=1.
  - GET_CMD: shift ADDR_W+1 bits. On the last bit, latch address, then R/W=1 -> RD_LOAD, else -> WR_SHIFT.
  - RD_LOAD: one clk. Shift register <- mem[addr]; miso_oe=1 -> RD_SHIFT.
  - RD_SHIFT: each sclk_fall drives the next bit. The first bit appears on the sclk_fall that follows the R/W bit's rise. After DATA_W bits: xfer_done pulse, addr increments -> RD_LOAD.
  - WR_SHIFT: shift DATA_W bits -> WR_STORE.
  - WR_STORE: one clk. mem[addr] <- shift register; xfer_done pulse; addr increments -> WR_SHIFT.
- Address increment wraps DEPTH-1 -> 0. Command addresses ≥ DEPTH are taken modulo DEPTH.
- cs_rise in any state: -> IDLE within 1 clk of the edge pulse; miso_oe=0, busy=0. A partially shifted write word is discarded (no memory write); partial read bits are simply dropped.
- cs_rise coincident with a WR_STORE cycle: the store completes, then -> IDLE.
- sclk edges while in IDLE are ignored.
- word_cnt saturates at 255.
- Reset mid-transaction: returns to IDLE; memory retains prior contents.
- cs_fall arriving while not in IDLE cannot occur (cs_rise is seen first); no special handling.

Optional Feature:
SPIMEM_BURST_EN
- Defined: burst behaviour as above; unlimited words per CS assertion with auto-increment.
- Undefined: exactly one data word per transaction. After the word the FSM enters HOLD: miso_oe=0, further sclk edges ignored, no memory writes, until cs_rise -> IDLE. word_cnt max 1.

Decomposition:
- Package spi_mem_pkg holds the state enum (IDLE, GET_CMD, RD_LOAD, RD_SHIFT, WR_SHIFT, WR_STORE, HOLD) and the R/W bit encoding constants.
- One natural sub-module, spi_pin_sync: SYNC_STAGES synchroniser plus rise/fall pulse outputs, instantiated for sclk, cs and mosi (mosi uses the level output only).
- Memory is an inferred array inside the top.

Test Plan:
1. Write then read (defaults): CS low; send cmd 0x02 (addr 0x01, W), then data 0x55; CS high. CS low; send cmd 0x03 (addr 0x01, R) -> MISO returns 0x55, one xfer_done per transaction.
2. Burst write with wrap (BURST_EN): cmd 0xFE (addr 0x7F, W), data 0xA1, 0xB2 -> mem[0x7F]=0xA1, mem[0x00]=0xB2, word_cnt=2. A burst read from 0x7F returns 0xA1 then 0xB2.
3. Abort: cmd 0x10 (addr 0x08, W), 5 data bits 10110, then CS high -> mem[0x08] unchanged, miso_oe=0 and busy=0 within SYNC_STAGES+2 clk.
4. Reset mid-read: cmd 0x03, assert reset after 3 data bits -> next clk all outputs at reset values; a fresh read of 0x01 still returns 0x55.
5. BURST_EN undefined: cmd 0x04 (addr 0x02, W), data 0x11, 0x22 -> mem[0x02]=0x11, mem[0x03] unchanged, word_cnt=1.
6. Idle noise: toggle sclk 16 times with CS high -> no state change, miso_oe=0, busy=0, memory unchanged.
